// File: rtl/async_event_arbiter.sv
// Async event arbiter: synchronises event lines, latches rising edges as
// pending requests and serves them one ID at a time on a valid/ready channel.
// Define ASYNC_EVT_ARB_FIXED_PRIO_EN for lowest-index-first selection.
module async_event_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] evt_async,
  input  logic [N_REQ-1:0] evt_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_id,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overflow,
  input  logic [N_REQ-1:0] ovf_clr
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  id_d;
  logic [ID_W-1:0]  pick;
  logic [N_REQ-1:0] sync_q [SYNC_STAGES];
  logic [N_REQ-1:0] prev_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] pending_d;
  logic [N_REQ-1:0] overflow_q;
  logic [N_REQ-1:0] overflow_d;
  logic [N_REQ-1:0] evt_edge;
  logic [N_REQ-1:0] set_v;
  logic [N_REQ-1:0] ovf_set;
  logic [N_REQ-1:0] acc_vec;
  logic             accept;
  logic             found;
  logic [ID_W-1:0]  cand;

`ifndef ASYNC_EVT_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]  last_q;
  logic [ID_W-1:0]  last_d;
  int               idx;
`endif

  assign out_valid = (state_q == GRANT);
  assign out_id    = id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign accept    = out_valid & out_ready;

  // Per-line synchroniser chain plus edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= evt_async;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge detection, request latching and sticky overflow
  always_comb begin
    acc_vec = '0;
    if (accept)
      acc_vec[id_q] = 1'b1;
    evt_edge   = sync_q[SYNC_STAGES-1] & ~prev_q;
    set_v      = evt_edge & ~evt_mask;
    pending_d  = (pending_q & ~acc_vec) | set_v;
    ovf_set    = set_v & pending_q & ~acc_vec;
    overflow_d = (overflow_q & ~ovf_clr) | ovf_set;
  end

`ifdef ASYNC_EVT_ARB_FIXED_PRIO_EN
  // Lowest-index pending line wins
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'(i);
      if (!found && pending_q[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end
`else
  // Round-robin scan starting just after the last granted line
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = int'(last_q) + off;
      if (idx >= N_REQ)
        idx = idx - N_REQ;
      cand = ID_W'(idx);
      if (!found && pending_q[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end
`endif

  // Grant FSM: latch one ID, hold it until the consumer accepts
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
`ifndef ASYNC_EVT_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          id_d    = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (out_ready) begin
`ifndef ASYNC_EVT_ARB_FIXED_PRIO_EN
          last_d  = id_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
`ifndef ASYNC_EVT_ARB_FIXED_PRIO_EN
      last_q     <= ID_W'(N_REQ - 1);
`endif
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
`ifndef ASYNC_EVT_ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

endmodule
